// File: rtl/i2c_sht40_pkg.sv
// Shared encodings and CRC helper for the SHT40 I2C measurement master.
package i2c_sht40_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_ACK   = 3'd5;
  localparam logic [2:0] ST_STOP  = 3'd6;
  localparam logic [2:0] ST_WAIT  = 3'd7;

  localparam logic [2:0] SCL_IDLE  = 3'd0;
  localparam logic [2:0] SCL_LOW1  = 3'd1;
  localparam logic [2:0] SCL_LOW2  = 3'd2;
  localparam logic [2:0] SCL_HIGH1 = 3'd3;
  localparam logic [2:0] SCL_HIGH2 = 3'd4;

  localparam logic [7:0] CRC_POLY   = 8'h31;
  localparam logic [7:0] CRC_INIT   = 8'hFF;
  localparam logic [3:0] READ_BYTES = 4'd6;

  // Sensirion CRC-8 over a 16-bit word, processed MSB first.
  function automatic logic [7:0] crc8(input logic [15:0] data);
    logic [7:0] crc;
    crc = CRC_INIT;
    for (int i = 15; i >= 0; i--) begin
      if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ CRC_POLY;
      else                  crc = {crc[6:0], 1'b0};
    end
    return crc;
  endfunction

endpackage

// File: rtl/i2c_scl_gen.sv
// SCL quarter-phase sequencer with clock-stretch hold and SDA timing strobes.
module i2c_scl_gen
  import i2c_sht40_pkg::*;
#(
  parameter int QUARTER_CYCLES = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       last,
  input  logic       scl_in,
  output logic       scl_out,
  output logic [2:0] phase,
  output logic       sda_change,
  output logic       sda_sample,
  output logic       phase_end
);

  localparam int CW = $clog2(QUARTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(QUARTER_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          stretch;
  logic          quarter_done;

  assign scl_out      = !(phase == SCL_LOW1 || phase == SCL_LOW2);
  assign stretch      = (phase == SCL_HIGH1) && scl_out && !scl_in;
  assign quarter_done = (phase != SCL_IDLE) && (cnt == CNT_MAX) && !stretch;
  assign sda_change   = quarter_done && (phase == SCL_LOW1);
  assign sda_sample   = quarter_done && (phase == SCL_HIGH1);
  assign phase_end    = quarter_done && (phase == SCL_HIGH2);

  // A bit frame is LOW1, LOW2, HIGH1, HIGH2; frames chain until the STOP frame ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= SCL_IDLE;
      cnt   <= '0;
    end else if (phase == SCL_IDLE) begin
      cnt <= '0;
      if (run) phase <= SCL_LOW1;
    end else if (!stretch) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        case (phase)
          SCL_LOW1:  phase <= SCL_LOW2;
          SCL_LOW2:  phase <= SCL_HIGH1;
          SCL_HIGH1: phase <= SCL_HIGH2;
          default:   phase <= last ? SCL_IDLE : SCL_LOW1;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_sht40_master.sv
// SHT40 measurement master: write the command, wait, read six bytes, CRC-check both words.
module i2c_sht40_master
  import i2c_sht40_pkg::*;
#(
  parameter int QUARTER_CYCLES   = 125,
  parameter int MEAS_WAIT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Processor_Ready,
  input  logic        i2c_writes,
  input  logic [6:0]  Peripheral_Address,
  input  logic [7:0]  Command_Data_Frames,
  input  logic        Sda_In,
  input  logic        Scl_In,
  output logic        Sda_Out,
  output logic        Scl_Out,
  output logic [15:0] Temperature_Output,
  output logic [15:0] Humidity_Output,
  output logic        Temp_Ready_Out,
  output logic        RH_Ready_Out,
  output logic        CRC_Error_Out,
  output logic        Ack_Error_Out,
  output logic [3:0]  Output_Received_Counter,
  output logic [2:0]  Master_State_Out,
  output logic [2:0]  Scl_State_Out
);

  localparam int WAIT_W = $clog2(MEAS_WAIT_CYCLES + 4 * QUARTER_CYCLES + 1);
  localparam logic [WAIT_W-1:0] START_HOLD = WAIT_W'(QUARTER_CYCLES - 1);
  localparam logic [WAIT_W-1:0] IDLE_GAP   = WAIT_W'(4 * QUARTER_CYCLES - 1);
  localparam logic [WAIT_W-1:0] MEAS_WAIT  = WAIT_W'(MEAS_WAIT_CYCLES - 1);

  logic [2:0]        state;
  logic [2:0]        prev_state;
  logic              sda;
  logic              read_phase;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        tx;
  logic [7:0]        rx;
  logic [7:0]        data_hi;
  logic [7:0]        data_lo;
  logic [3:0]        byte_cnt;
  logic              sda_change;
  logic              sda_sample;
  logic              phase_end;
  logic              enter_start;

  assign Sda_Out                 = sda;
  assign Master_State_Out        = state;
  assign Output_Received_Counter = byte_cnt;

  assign enter_start = (wait_cnt == '0) &&
                       ((state == ST_IDLE && Processor_Ready && i2c_writes) || state == ST_WAIT);

  i2c_scl_gen #(
    .QUARTER_CYCLES(QUARTER_CYCLES)
  ) u_scl (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (state == ST_ADDR),
    .last       (state == ST_STOP),
    .scl_in     (Scl_In),
    .scl_out    (Scl_Out),
    .phase      (Scl_State_Out),
    .sda_change (sda_change),
    .sda_sample (sda_sample),
    .phase_end  (phase_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      prev_state         <= ST_IDLE;
      sda                <= 1'b1;
      read_phase         <= 1'b0;
      wait_cnt           <= '0;
      bit_cnt            <= '0;
      tx                 <= '0;
      rx                 <= '0;
      data_hi            <= '0;
      data_lo            <= '0;
      byte_cnt           <= '0;
      Temperature_Output <= '0;
      Humidity_Output    <= '0;
      Temp_Ready_Out     <= 1'b0;
      RH_Ready_Out       <= 1'b0;
      CRC_Error_Out      <= 1'b0;
      Ack_Error_Out      <= 1'b0;
    end else begin
      Temp_Ready_Out <= 1'b0;
      RH_Ready_Out   <= 1'b0;
      case (state)
        ST_IDLE, ST_WAIT: begin
          sda <= 1'b1;
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        end
        ST_START: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            state   <= ST_ADDR;
            tx      <= {Peripheral_Address, read_phase};
            bit_cnt <= '0;
          end
        end
        ST_ADDR, ST_WRITE: begin
          if (sda_change) begin
            sda <= tx[7];
            tx  <= {tx[6:0], 1'b0};
          end
          if (phase_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state      <= ST_ACK;
              prev_state <= state;
            end
          end
        end
        ST_READ: begin
          if (sda_change) sda <= 1'b1;
          if (sda_sample) rx <= {rx[6:0], Sda_In};
          if (phase_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state      <= ST_ACK;
              prev_state <= ST_READ;
              byte_cnt   <= byte_cnt + 1'b1;
              // Bytes 3 and 6 are checksums over the two bytes held in data_hi/data_lo.
              case (byte_cnt)
                4'd0, 4'd3: data_hi <= rx;
                4'd1, 4'd4: data_lo <= rx;
                4'd2: begin
                  if (crc8({data_hi, data_lo}) == rx) begin
                    Temperature_Output <= {data_hi, data_lo};
                    Temp_Ready_Out     <= 1'b1;
                  end else begin
                    CRC_Error_Out <= 1'b1;
                  end
                end
                4'd5: begin
                  if (crc8({data_hi, data_lo}) == rx) begin
                    Humidity_Output <= {data_hi, data_lo};
                    RH_Ready_Out    <= 1'b1;
                  end else begin
                    CRC_Error_Out <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        ST_ACK: begin
          if (sda_change) sda <= (prev_state != ST_READ) || (byte_cnt == READ_BYTES);
          if (sda_sample && prev_state != ST_READ && Sda_In) Ack_Error_Out <= 1'b1;
          if (phase_end) begin
            bit_cnt <= '0;
            if (prev_state == ST_READ) begin
              state <= (byte_cnt == READ_BYTES) ? ST_STOP : ST_READ;
            end else if (Ack_Error_Out) begin
              state <= ST_STOP;
            end else if (prev_state == ST_ADDR) begin
              if (read_phase) begin
                state <= ST_READ;
              end else begin
                state <= ST_WRITE;
                tx    <= Command_Data_Frames;
              end
            end else begin
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (sda_change) sda <= 1'b0;
          if (sda_sample) sda <= 1'b1;
          if (phase_end) begin
            if (read_phase || Ack_Error_Out) begin
              state    <= ST_IDLE;
              wait_cnt <= IDLE_GAP;
            end else begin
              state      <= ST_WAIT;
              wait_cnt   <= MEAS_WAIT;
              read_phase <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // START condition: SDA falls while SCL is still released.
      if (enter_start) begin
        state         <= ST_START;
        sda           <= 1'b0;
        wait_cnt      <= START_HOLD;
        byte_cnt      <= '0;
        CRC_Error_Out <= 1'b0;
        Ack_Error_Out <= 1'b0;
        if (state == ST_IDLE) read_phase <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_sht40_master.sv
// Directed bench for i2c_sht40_master with an open-drain SHT40 slave model and scoreboards.
module tb_i2c_sht40_master;

  localparam int Q     = 4;
  localparam int MW    = 200;
  localparam int BOUND = 6000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Processor_Ready = 1'b0;
  logic i2c_writes = 1'b0;
  logic [6:0] Peripheral_Address = 7'h44;
  logic [7:0] Command_Data_Frames = 8'hFD;
  logic Sda_Out, Scl_Out;
  logic [15:0] Temperature_Output, Humidity_Output;
  logic Temp_Ready_Out, RH_Ready_Out, CRC_Error_Out, Ack_Error_Out;
  logic [3:0] Output_Received_Counter;
  logic [2:0] Master_State_Out, Scl_State_Out;

  logic slave_sda_low = 1'b0;
  logic slave_scl_low = 1'b0;
  logic sda_line, scl_line;
  assign sda_line = Sda_Out & ~slave_sda_low;
  assign scl_line = Scl_Out & ~slave_scl_low;

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_bus_q[$];
  logic [15:0] exp_temp_q[$];
  logic [15:0] exp_rh_q[$];
  int temp_pulses = 0;
  int rh_pulses = 0;
  logic saw_wait = 1'b0;
  logic saw_stop = 1'b0;

  logic       s_active = 1'b0;
  logic       s_sending = 1'b0;
  logic       s_is_addr = 1'b0;
  logic       s_ack_en = 1'b1;
  logic       s_master_ack = 1'b0;
  logic [7:0] s_shift = 8'h00;
  logic [7:0] s_last = 8'h00;
  logic [7:0] s_data[6];
  int         s_bit = 0;
  int         s_idx = 0;
  logic       prev_sda = 1'b1;
  logic       prev_scl = 1'b1;

  i2c_sht40_master #(
    .QUARTER_CYCLES(Q),
    .MEAS_WAIT_CYCLES(MW)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .Processor_Ready         (Processor_Ready),
    .i2c_writes              (i2c_writes),
    .Peripheral_Address      (Peripheral_Address),
    .Command_Data_Frames     (Command_Data_Frames),
    .Sda_In                  (sda_line),
    .Scl_In                  (scl_line),
    .Sda_Out                 (Sda_Out),
    .Scl_Out                 (Scl_Out),
    .Temperature_Output      (Temperature_Output),
    .Humidity_Output         (Humidity_Output),
    .Temp_Ready_Out          (Temp_Ready_Out),
    .RH_Ready_Out            (RH_Ready_Out),
    .CRC_Error_Out           (CRC_Error_Out),
    .Ack_Error_Out           (Ack_Error_Out),
    .Output_Received_Counter (Output_Received_Counter),
    .Master_State_Out        (Master_State_Out),
    .Scl_State_Out           (Scl_State_Out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Slave model: decodes START/STOP and bit edges, acks written bytes, serves read data.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      s_active = 1'b0;
      s_sending = 1'b0;
      slave_sda_low = 1'b0;
    end else if (prev_scl && scl_line && prev_sda && !sda_line) begin
      s_active = 1'b1;
      s_sending = 1'b0;
      s_is_addr = 1'b1;
      s_bit = -1;
      slave_sda_low = 1'b0;
    end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
      s_active = 1'b0;
      s_sending = 1'b0;
      slave_sda_low = 1'b0;
    end else if (s_active && !prev_scl && scl_line) begin
      if (!s_sending && s_bit >= 0 && s_bit < 8) s_shift = {s_shift[6:0], sda_line};
      if (s_sending && s_bit == 8) s_master_ack = !sda_line;
    end else if (s_active && prev_scl && !scl_line) begin
      if (!s_sending) begin
        if (s_bit == 7) begin
          s_last = s_shift;
          checkOutput("bus_byte_expected", 32'(exp_bus_q.size() != 0), 32'd1);
          if (exp_bus_q.size() != 0) checkOutput("bus_byte", 32'(s_shift), 32'(exp_bus_q.pop_front()));
          slave_sda_low = s_ack_en;
          s_bit = 8;
        end else if (s_bit == 8) begin
          slave_sda_low = 1'b0;
          s_bit = 0;
          if (s_is_addr && s_last[0] && s_ack_en) begin
            s_sending = 1'b1;
            s_idx = 0;
            slave_sda_low = !s_data[0][7];
          end
          s_is_addr = 1'b0;
        end else begin
          s_bit++;
        end
      end else begin
        if (s_bit < 7) begin
          s_bit++;
          slave_sda_low = !s_data[s_idx][7 - s_bit];
        end else if (s_bit == 7) begin
          s_bit = 8;
          slave_sda_low = 1'b0;
        end else begin
          s_bit = 0;
          s_idx++;
          if (s_master_ack && s_idx < 6) begin
            slave_sda_low = !s_data[s_idx][7];
          end else begin
            slave_sda_low = 1'b0;
            s_sending = 1'b0;
          end
        end
      end
    end
    prev_sda = sda_line;
    prev_scl = scl_line;
  end

  // Output monitor: every Ready pulse pops and checks the next expected word.
  initial forever begin
    @(negedge clk);
    if (Master_State_Out === 3'd7) saw_wait = 1'b1;
    if (Master_State_Out === 3'd6) saw_stop = 1'b1;
    if (Temp_Ready_Out === 1'b1) begin
      temp_pulses++;
      checkOutput("temp_pulse_expected", 32'(exp_temp_q.size() != 0), 32'd1);
      if (exp_temp_q.size() != 0) checkOutput("temp_word", 32'(Temperature_Output), 32'(exp_temp_q.pop_front()));
    end
    if (RH_Ready_Out === 1'b1) begin
      rh_pulses++;
      checkOutput("rh_pulse_expected", 32'(exp_rh_q.size() != 0), 32'd1);
      if (exp_rh_q.size() != 0) checkOutput("rh_word", 32'(Humidity_Output), 32'(exp_rh_q.pop_front()));
    end
  end

  task automatic applyStimulus(input logic [47:0] bytes, input logic ack_en,
                               input logic push_temp, input logic push_rh);
    int n;
    for (int i = 0; i < 6; i++) s_data[i] = bytes[47 - 8*i -: 8];
    s_ack_en = ack_en;
    exp_bus_q.push_back(8'h88);
    if (ack_en) begin
      exp_bus_q.push_back(8'hFD);
      exp_bus_q.push_back(8'h89);
    end
    if (push_temp) exp_temp_q.push_back(bytes[47:32]);
    if (push_rh) exp_rh_q.push_back(bytes[23:8]);
    temp_pulses = 0;
    rh_pulses = 0;
    saw_wait = 1'b0;
    saw_stop = 1'b0;
    Processor_Ready = 1'b1;
    i2c_writes = 1'b1;
    n = 0;
    while (Master_State_Out === 3'd0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checkOutput("start_timeout", 32'(n >= BOUND), 32'd0);
    Processor_Ready = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (Master_State_Out !== 3'd0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle_timeout"}, 32'(n >= BOUND), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int sda_changes;
    logic sda_ref;

    repeat (3) @(negedge clk);
    checkOutput("reset_lines", {30'd0, Sda_Out, Scl_Out}, 32'd3);
    checkOutput("reset_states", {26'd0, Master_State_Out, Scl_State_Out}, 32'd0);
    checkOutput("reset_words", {Temperature_Output, Humidity_Output}, 32'd0);
    checkOutput("reset_flags", {24'd0, Output_Received_Counter, Temp_Ready_Out, RH_Ready_Out,
                                CRC_Error_Out, Ack_Error_Out}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] i2c_writes low keeps the master idle");
    Processor_Ready = 1'b1;
    i2c_writes = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Master_State_Out !== 3'd0 || Sda_Out !== 1'b1 || Scl_Out !== 1'b1) n++;
    end
    checkOutput("disabled_idle_cycles", 32'(n), 32'd0);
    Processor_Ready = 1'b0;

    $display("[TB] full measurement cycle");
    applyStimulus(48'hBEEF92666693, 1'b1, 1'b1, 1'b1);
    waitIdle("good");
    checkOutput("good_temp", 32'(Temperature_Output), 32'h0000BEEF);
    checkOutput("good_rh", 32'(Humidity_Output), 32'h00006666);
    checkOutput("good_pulses", {temp_pulses[15:0], rh_pulses[15:0]}, 32'h00010001);
    checkOutput("good_errors", {30'd0, CRC_Error_Out, Ack_Error_Out}, 32'd0);
    checkOutput("good_counter", 32'(Output_Received_Counter), 32'd6);
    checkOutput("good_saw_wait", 32'(saw_wait), 32'd1);
    checkOutput("good_bus_left", 32'(exp_bus_q.size()), 32'd0);

    $display("[TB] bad temperature checksum");
    applyStimulus(48'hBEEF00666693, 1'b1, 1'b0, 1'b1);
    waitIdle("badcrc");
    checkOutput("badcrc_temp_kept", 32'(Temperature_Output), 32'h0000BEEF);
    checkOutput("badcrc_flag", 32'(CRC_Error_Out), 32'd1);
    checkOutput("badcrc_rh", 32'(Humidity_Output), 32'h00006666);
    checkOutput("badcrc_pulses", {temp_pulses[15:0], rh_pulses[15:0]}, 32'h00000001);

    $display("[TB] address not acknowledged");
    applyStimulus(48'hBEEF92666693, 1'b0, 1'b0, 1'b0);
    waitIdle("nack");
    checkOutput("nack_flag", 32'(Ack_Error_Out), 32'd1);
    checkOutput("nack_crc_cleared", 32'(CRC_Error_Out), 32'd0);
    checkOutput("nack_counter", 32'(Output_Received_Counter), 32'd0);
    checkOutput("nack_stop_no_wait", {30'd0, saw_stop, saw_wait}, 32'd2);
    checkOutput("nack_lines_released", {30'd0, Sda_Out, Scl_Out}, 32'd3);
    checkOutput("nack_bus_left", 32'(exp_bus_q.size()), 32'd0);

    $display("[TB] clock stretch on third address bit");
    applyStimulus(48'hBEEF92666693, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (!(s_active && s_is_addr && s_bit == 2 && Scl_State_Out === 3'd2) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stretch_reach_timeout", 32'(n >= BOUND), 32'd0);
    slave_scl_low = 1'b1;
    n = 0;
    while (Scl_State_Out !== 3'd3 && n < 4 * Q) begin
      @(negedge clk);
      n++;
    end
    sda_ref = Sda_Out;
    sda_changes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Sda_Out !== sda_ref) sda_changes++;
    end
    checkOutput("stretch_phase_held", 32'(Scl_State_Out), 32'd3);
    checkOutput("stretch_sda_stable", 32'(sda_changes), 32'd0);
    slave_scl_low = 1'b0;
    waitIdle("stretch");
    checkOutput("stretch_temp", 32'(Temperature_Output), 32'h0000BEEF);
    checkOutput("stretch_bus_left", 32'(exp_bus_q.size()), 32'd0);
    checkOutput("stretch_errors", {30'd0, CRC_Error_Out, Ack_Error_Out}, 32'd0);

    $display("[TB] reset during third read byte");
    applyStimulus(48'hBEEF92666693, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(Output_Received_Counter === 4'd2 && Master_State_Out === 3'd4) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midreset_reach_timeout", 32'(n >= BOUND), 32'd0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_lines", {30'd0, Sda_Out, Scl_Out}, 32'd3);
    checkOutput("midreset_states", {26'd0, Master_State_Out, Scl_State_Out}, 32'd0);
    checkOutput("midreset_counter", 32'(Output_Received_Counter), 32'd0);
    checkOutput("midreset_words", {Temperature_Output, Humidity_Output}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * Q) @(negedge clk);
    checkOutput("midreset_stays_idle", 32'(Master_State_Out), 32'd0);
    checkOutput("final_queues", 32'(exp_bus_q.size() + exp_temp_q.size() + exp_rh_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_sht40_master.md
Name: i2c_sht40_master

Overview:
- Single-master I2C controller that runs one SHT40 measurement cycle and delivers checked 16-bit temperature and humidity words.
- Cycle: write command (0xFD, high-precision) to the sensor, wait the conversion time, read 6 bytes, verify both CRC-8 checksums.
- Drives open-drain SDA/SCL enables. The top level turns Out=1 into release (Z) and Out=0 into drive-low, and feeds the resolved bus back on the In ports.

Parameters:
- QUARTER_CYCLES, 125, clk cycles per SCL quarter-period (SCL period = 4*QUARTER_CYCLES; 100 kHz at 50 MHz).
- MEAS_WAIT_CYCLES, 500000, clk cycles between write-phase STOP and read-phase START (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- Processor_Ready  in  1  level: start or continue measurement cycles
- i2c_writes  in  1  1 = cycles enabled; 0 = stay in IDLE
- Peripheral_Address  in  7  7-bit target address (0x44)
- Command_Data_Frames  in  8  command byte (0xFD)
- Sda_In  in  1  resolved SDA
- Scl_In  in  1  resolved SCL (clock-stretch detect)
- Sda_Out  out  1  1 = release, 0 = pull low
- Scl_Out  out  1  1 = release, 0 = pull low
- Temperature_Output  out  16  last CRC-valid raw temperature word
- Humidity_Output  out  16  last CRC-valid raw RH word
- Temp_Ready_Out  out  1  1-cycle pulse when temperature updated
- RH_Ready_Out  out  1  1-cycle pulse when RH updated
- CRC_Error_Out  out  1  sticky CRC mismatch flag, cleared at next START
- Ack_Error_Out  out  1  sticky NACK-from-slave flag, cleared at next START
- Output_Received_Counter  out  4  read bytes completed this cycle, 0..6
- Master_State_Out  out  3  FSM state encoding
- Scl_State_Out  out  3  SCL phase encoding

Behaviour:
- Reset (rst_n=0 at clk edge):
  - Sda_Out=1, Scl_Out=1; all data outputs, flags and counters 0.
  - Master FSM = IDLE; SCL phase = IDLE.
- SCL phases (Scl_State_Out): 0 IDLE (SCL released), 1 LOW1, 2 LOW2, 3 HIGH1, 4 HIGH2. Each phase lasts QUARTER_CYCLES.
- SDA timing:
  - SDA changes only at the LOW1→LOW2 boundary.
  - Master samples SDA at the HIGH1→HIGH2 boundary.
- Clock stretching: in HIGH1, if Scl_Out=1 but Scl_In=0, the phase counter holds until Scl_In=1.
- Master states (Master_State_Out): 0 IDLE, 1 START, 2 ADDR, 3 WRITE, 4 READ, 5 ACK, 6 STOP, 7 WAIT.
- IDLE → START when Processor_Ready=1 and i2c_writes=1.
- START: SDA falls while SCL is high, held for one quarter; then SCL goes low.
- ADDR: shift out {Peripheral_Address, rw} MSB first. rw=0 in the write phase, 1 in the read phase.
- ACK after ADDR or WRITE:
  - Master releases SDA for the 9th bit and samples it.
  - Sample 1 → Ack_Error_Out=1, go to STOP, then IDLE (no WAIT, no read).
- Write phase: ADDR(W), ACK, WRITE(Command_Data_Frames), ACK, STOP, then WAIT for MEAS_WAIT_CYCLES.
- Read phase: START, ADDR(R), ACK, then READ 6 bytes.
  - After each byte, Output_Received_Counter increments.
  - Master drives ACK (0) after bytes 1–5 and NACK (released) after byte 6, then STOP.
- STOP: SDA low during SCL low, SCL released, then SDA released a quarter later. End in IDLE with Output_Received_Counter reset to 0 at the next START.
- CRC-8 check (poly 0x31, init 0xFF, no reflection, no final XOR):
  - Covers bytes 1–2 against byte 3 (temperature) and bytes 4–5 against byte 6 (RH).
  - Match → update the matching output register and pulse its Ready for 1 cycle, in the cycle after byte 3 or byte 6 completes.
  - Mismatch → output unchanged, CRC_Error_Out=1.
- Level operation: if Processor_Ready is still 1 on return to IDLE, the next cycle starts after one full SCL period of idle.
- Processor_Ready falling mid-cycle does not abort the current cycle.
- Reset mid-transfer: both lines released immediately on the reset cycle. No STOP is generated.

Decomposition:
- Package i2c_sht40_pkg holds:
  - master-state and SCL-phase enumerations (3-bit);
  - CRC_POLY=8'h31 and CRC_INIT=8'hFF;
  - READ_BYTES=6.
- Sub-module i2c_scl_gen contains the phase counter, stretch hold and phase strobes (sda_change, sda_sample, phase_end). The master FSM and CRC logic stay in the top block.

Test Plan:
- Full cycle, slave model acks and returns BE EF 92 66 66 93 → Temperature_Output=0xBEEF, Humidity_Output=0x6666, one pulse each on Temp_Ready_Out and RH_Ready_Out, CRC_Error_Out=0. Bus carries 0x88, 0xFD, then 0x89.
- Bad CRC: bytes BE EF 00 66 66 93 → temperature unchanged, CRC_Error_Out=1, RH updated to 0x6666.
- Address NACK (slave never pulls SDA) → Ack_Error_Out=1, STOP issued, no WAIT, Output_Received_Counter stays 0.
- Slave holds SCL low 40 cycles in the 3rd address bit → no SDA transition during the hold, remaining bits correct.
- Reset asserted during READ byte 3 → next cycle Sda_Out=1, Scl_Out=1, state 0, counter 0, outputs 0.
- i2c_writes=0 with Processor_Ready=1 → stays IDLE, both lines released.
